instr_fetch_unit: RTL and testbench

//  Upstream neighbour of the controller FSM. Holds the program counter, instruction memory and

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/instr_mem.sv | 27 ++
 rtl/instr_fetch_unit.sv | 108 ++++++++++
 tb/tb_instr_fetch_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, default address width,
// opcode encodings and the fetch unit's state type.
package cpu_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 7;

    // Opcode field lives in Instruction[15:12]
    localparam logic [3:0] OP_NOOP  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_HALT  = 4'b0101;

    typedef enum logic {
        FS_LOAD = 1'b0,
        FS_RUN  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instr_mem.sv
// Instruction memory: synchronous single write port, asynchronous read port.
// Contents are deliberately not reset so a loaded program survives Rst.
module instr_mem #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16
) (
    input  logic              Clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    // Write port: one word per clock while we is high
    always_ff @(posedge Clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read port is combinational from the address
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: program counter, instruction register and the
// LOAD/RUN sequencing that fills instruction memory before execution.
//
// Handshake: the controller strobes (PCClr, PCUp, IRLd) are single-cycle
// commands that are honoured on a posedge only while Ready=1; while Ready=0
// they are ignored whatever their value, so the controller must wait for
// Ready before issuing them. Ready never drops except through Rst.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DATA_W = cpu_pkg::INSTR_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              PCClr,
    input  logic              PCUp,
    input  logic              IRLd,
    input  logic              LdEn,
    input  logic [ADDR_W-1:0] LdAddr,
    input  logic [DATA_W-1:0] LdData,
    input  logic              LdDone,
    output logic [DATA_W-1:0] Instruction,
    output logic [ADDR_W-1:0] PC,
    output logic              Ready,
    output logic              PCWrap,
    output fetch_state_t      DbgState
);

    localparam logic [ADDR_W-1:0] PC_MAX = {ADDR_W{1'b1}};

    fetch_state_t      state_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q;
    logic              ready_q;
    logic              wrap_q, wrap_d;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_we;

    // Memory is writable only during LOAD, so reads in RUN never see a write
    assign mem_we = (state_q == FS_LOAD) && LdEn;

    instr_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .Clk   (Clk),
        .we    (mem_we),
        .waddr (LdAddr),
        .wdata (LdData),
        .raddr (pc_q),
        .rdata (mem_rdata)
    );

    // Next PC and wrap flag for RUN: clear beats increment, wrap is sticky
    always_comb begin
        pc_d   = pc_q;
        wrap_d = wrap_q;
        if (PCClr) begin
            pc_d   = '0;
            wrap_d = 1'b0;
        end else if (PCUp) begin
            pc_d = pc_q + ADDR_W'(1);
            if (pc_q == PC_MAX) begin
                wrap_d = 1'b1;
            end
        end
    end

    // Fetch FSM with registered PC, IR, Ready and wrap flag
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= FS_LOAD;
            ready_q <= 1'b0;
            pc_q    <= '0;
            ir_q    <= '0;
            wrap_q  <= 1'b0;
        end else begin
            case (state_q)
                FS_LOAD: begin
                    if (LdDone) begin
                        state_q <= FS_RUN;
                        ready_q <= 1'b1;
                    end
                end
                FS_RUN: begin
                    // IR captures mem[PC] using the PC from before this edge
                    if (IRLd) begin
                        ir_q <= mem_rdata;
                    end
                    pc_q   <= pc_d;
                    wrap_q <= wrap_d;
                end
                default: begin
                    state_q <= FS_LOAD;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign Instruction = ir_q;
    assign PC          = pc_q;
    assign Ready       = ready_q;
    assign PCWrap      = wrap_q;
    assign DbgState    = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a table of single-cycle vectors for load,
// fetch, priority and write protection, plus hand sequences for reset,
// PC wrap and reset-then-rerun.
module tb_instr_fetch_unit;
    import cpu_pkg::*;

    localparam int AW = 7;
    localparam int DW = 16;

    logic          Clk;
    logic          Rst;
    logic          PCClr, PCUp, IRLd, LdEn, LdDone;
    logic [AW-1:0] LdAddr;
    logic [DW-1:0] LdData;
    logic [DW-1:0] Instruction;
    logic [AW-1:0] PC;
    logic          Ready, PCWrap;
    fetch_state_t  DbgState;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          pcclr, pcup, irld, lden, lddone;
        logic [AW-1:0] ldaddr;
        logic [DW-1:0] lddata;
        logic [AW-1:0] exp_pc;
        logic [DW-1:0] exp_instr;
        logic          exp_ready, exp_wrap;
    } vec_t;

    vec_t vecs[11];

    instr_fetch_unit #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .PCClr       (PCClr),
        .PCUp        (PCUp),
        .IRLd        (IRLd),
        .LdEn        (LdEn),
        .LdAddr      (LdAddr),
        .LdData      (LdData),
        .LdDone      (LdDone),
        .Instruction (Instruction),
        .PC          (PC),
        .Ready       (Ready),
        .PCWrap      (PCWrap),
        .DbgState    (DbgState)
    );

    // Clock and reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic vec_t mk(input logic c, input logic u, input logic l,
                                input logic le, input logic ld,
                                input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input logic [AW-1:0] pc, input logic [DW-1:0] ins,
                                input logic rdy, input logic wr);
        vec_t v;
        v.pcclr = c; v.pcup = u; v.irld = l; v.lden = le; v.lddone = ld;
        v.ldaddr = a; v.lddata = d;
        v.exp_pc = pc; v.exp_instr = ins; v.exp_ready = rdy; v.exp_wrap = wr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [AW-1:0] pc,
                             input logic [DW-1:0] ins, input logic rdy, input logic wr);
        check({tag, ".pc"}, 32'(PC), 32'(pc));
        check({tag, ".instr"}, 32'(Instruction), 32'(ins));
        check({tag, ".ready"}, 32'(Ready), 32'(rdy));
        check({tag, ".wrap"}, 32'(PCWrap), 32'(wr));
    endtask

    task automatic idle_inputs();
        PCClr = 0; PCUp = 0; IRLd = 0; LdEn = 0; LdDone = 0;
        LdAddr = '0; LdData = '0;
    endtask

    // Inputs change on negedge; outputs are sampled on the following negedge
    task automatic step();
        @(negedge Clk);
    endtask

    initial begin
        // Vectors applied one per clock straight after reset release
        //            clr up ld  en done addr  data      pc    instr     rdy wrap
        vecs[0]  = mk(0, 1, 1,  1, 0,  7'd0, 16'h2123, 7'd0, 16'h0000, 0, 0); // strobes ignored in LOAD
        vecs[1]  = mk(1, 1, 1,  1, 0,  7'd1, 16'h3456, 7'd0, 16'h0000, 0, 0);
        vecs[2]  = mk(0, 0, 0,  1, 1,  7'd2, 16'h5000, 7'd0, 16'h0000, 1, 0); // write + go together
        vecs[3]  = mk(0, 1, 1,  0, 0,  7'd0, 16'h0000, 7'd1, 16'h2123, 1, 0); // FETCH
        vecs[4]  = mk(0, 1, 1,  0, 0,  7'd0, 16'h0000, 7'd2, 16'h3456, 1, 0); // FETCH
        vecs[5]  = mk(1, 1, 1,  0, 0,  7'd0, 16'h0000, 7'd0, 16'h5000, 1, 0); // clear wins, IR uses old PC
        vecs[6]  = mk(0, 0, 0,  1, 1,  7'd0, 16'hFFFF, 7'd0, 16'h5000, 1, 0); // write attempt in RUN
        vecs[7]  = mk(0, 0, 1,  0, 0,  7'd0, 16'h0000, 7'd0, 16'h2123, 1, 0); // mem[0] intact
        vecs[8]  = mk(0, 0, 0,  0, 0,  7'd0, 16'h0000, 7'd0, 16'h2123, 1, 0); // hold
        vecs[9]  = mk(0, 1, 0,  0, 0,  7'd0, 16'h0000, 7'd1, 16'h2123, 1, 0); // PCUp only, IR holds
        vecs[10] = mk(1, 0, 1,  0, 0,  7'd0, 16'h0000, 7'd0, 16'h3456, 1, 0); // IRLd+PCClr uses old PC

        // Reset held two clocks with strobes active
        idle_inputs();
        PCUp = 1; IRLd = 1;
        Rst = 0;
        repeat (2) step();
        check_all("reset", 7'd0, 16'h0000, 1'b0, 1'b0);
        check("reset.state", 32'(DbgState), 32'(FS_LOAD));
        Rst = 1;

        for (int i = 0; i < 11; i++) begin
            PCClr = vecs[i].pcclr; PCUp = vecs[i].pcup; IRLd = vecs[i].irld;
            LdEn = vecs[i].lden; LdDone = vecs[i].lddone;
            LdAddr = vecs[i].ldaddr; LdData = vecs[i].lddata;
            step();
            check_all($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_instr,
                      vecs[i].exp_ready, vecs[i].exp_wrap);
        end
        idle_inputs();

        // Wrap: PC is 0 here; 127 increments reach the top, the 128th wraps
        PCUp = 1;
        repeat (127) step();
        check("wrap.pc_max", 32'(PC), 32'd127);
        check("wrap.pre_flag", 32'(PCWrap), 32'd0);
        step();
        check("wrap.pc0", 32'(PC), 32'd0);
        check("wrap.flag", 32'(PCWrap), 32'd1);
        step();
        check("wrap.sticky_pc", 32'(PC), 32'd1);
        check("wrap.sticky", 32'(PCWrap), 32'd1);
        PCUp = 0; PCClr = 1;
        step();
        check("wrap.clr_pc", 32'(PC), 32'd0);
        check("wrap.clr_flag", 32'(PCWrap), 32'd0);
        PCClr = 0;

        // Advance PC so that reset visibly clears it
        PCUp = 1;
        repeat (2) step();
        PCUp = 0;
        check("pre_rst.pc", 32'(PC), 32'd2);

        // Asynchronous reset mid-RUN, then X strobes while in LOAD
        #2 Rst = 0;
        #1;
        check_all("midrst", 7'd0, 16'h0000, 1'b0, 1'b0);
        step();
        Rst = 1;
        PCClr = 1'bx; PCUp = 1'bx; IRLd = 1'bx;
        step();
        check_all("load_x", 7'd0, 16'h0000, 1'b0, 1'b0);

        // LdDone alone restarts the retained program
        idle_inputs();
        LdDone = 1;
        step();
        LdDone = 0;
        check_all("rerun.ready", 7'd0, 16'h0000, 1'b1, 1'b0);
        PCUp = 1; IRLd = 1;
        step();
        check_all("rerun.fetch0", 7'd1, 16'h2123, 1'b1, 1'b0);
        step();
        check_all("rerun.fetch1", 7'd2, 16'h3456, 1'b1, 1'b0);
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
